// File: rtl/kong.sv
// kong -- enemy-character controller for the Kong sprite.
//
// Holds an IDLE/PLAY state, patrols horizontally between X_MIN and X_MAX
// while playing, and advances a 4-frame animation once per 16 game ticks.
// A game tick is one clk cycle out of every TICK_DIV while in PLAY.
//
// Ports:
//   clk              in   1   system clock, rising edge
//   rst              in   1   asynchronous reset, active high
//   start            in   1   level, begin play (taken only in IDLE)
//   over             in   1   level, game over (taken only in PLAY)
//   x                out  10  sprite left x
//   y                out  9   sprite top y
//   state            out  1   0 = IDLE, 1 = PLAY
//   animation_state  out  2   animation frame 0..3
//   anicnt           out  4   tick count within the current frame
//
// Optional feature: define KONG_JUMP_EN to make Kong hop up 8 pixels
// while animation frame 2 is showing. Without it y stays at Y_INIT.
module kong #(
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 64,
  parameter int X_MIN    = 160,
  parameter int X_MAX    = 480,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 416667
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       over,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       state,
  output logic [1:0] animation_state,
  output logic [3:0] anicnt
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // Bound arithmetic is done one bit wider so x + STEP can never wrap.
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] XMIN11 = 11'(X_MIN);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  XMAX10 = 10'(X_MAX);
  localparam logic [9:0]  XMIN10 = 10'(X_MIN);
  localparam logic [9:0]  STEP10 = 10'(STEP);
  localparam logic [9:0]  XINIT  = 10'(X_INIT);
  localparam logic [8:0]  YINIT  = 9'(Y_INIT);
`ifdef KONG_JUMP_EN
  localparam logic [8:0]  YJUMP  = 9'(Y_INIT - 8);
`endif

  state_t           state_q, state_d;
  logic [9:0]       x_q, x_d;
  logic [8:0]       y_q, y_d;
  logic [1:0]       anim_q, anim_d;
  logic [3:0]       anicnt_q, anicnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             left_q, left_d;   // 1 = moving left
  logic             tick;

  assign tick = (state_q == PLAY) && (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    anim_d   = anim_q;
    anicnt_d = anicnt_q;
    div_d    = div_q;
    left_d   = left_q;
    if (state_q == IDLE) begin
      // over is ignored here, so start+over together still enters PLAY
      if (start) state_d = PLAY;
    end else if (over) begin
      // freeze everything except the divider, so the next PLAY stint
      // again waits a full TICK_DIV before its first tick
      state_d = IDLE;
      div_d   = '0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        anicnt_d = anicnt_q + 4'd1;
        if (anicnt_q == 4'hF) anim_d = anim_q + 2'd1;
        if (!left_q) begin
          if ({1'b0, x_q} + STEP11 >= XMAX11) begin
            x_d    = XMAX10;
            left_d = 1'b1;
          end else begin
            x_d = x_q + STEP10;
          end
        end else begin
          if ({1'b0, x_q} <= XMIN11 + STEP11) begin
            x_d    = XMIN10;
            left_d = 1'b0;
          end else begin
            x_d = x_q - STEP10;
          end
        end
      end
`ifdef KONG_JUMP_EN
      // follows the frame being loaded this edge
      y_d = (anim_d == 2'd2) ? YJUMP : YINIT;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= XINIT;
      y_q      <= YINIT;
      anim_q   <= 2'd0;
      anicnt_q <= 4'd0;
      div_q    <= '0;
      left_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      anim_q   <= anim_d;
      anicnt_q <= anicnt_d;
      div_q    <= div_d;
      left_q   <= left_d;
    end
  end

  assign state           = state_q;
  assign x               = x_q;
  assign y               = y_q;
  assign animation_state = anim_q;
  assign anicnt          = anicnt_q;

endmodule

// File: tb/tb_kong.sv
module tb_kong;

  localparam int TICK_DIV = 4;
  localparam int STEP     = 2;
  localparam int X_INIT   = 320;
  localparam int X_MIN    = 316;
  localparam int X_MAX    = 326;
  localparam int Y_INIT   = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       over;
  logic [9:0] x;
  logic [8:0] y;
  logic       state;
  logic [1:0] animation_state;
  logic [3:0] anicnt;

  kong #(
    .X_INIT(X_INIT), .Y_INIT(Y_INIT), .X_MIN(X_MIN), .X_MAX(X_MAX),
    .STEP(STEP), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .over(over),
    .x(x), .y(y), .state(state),
    .animation_state(animation_state), .anicnt(anicnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: position/direction plus a running count of ticks
  // taken; frame and in-frame counter are derived from that count.
  int m_play, m_phase, m_x, m_dir, m_ticks, m_y;

  function automatic int m_frame();
    return (m_ticks / 16) % 4;
  endfunction

  task automatic m_reset();
    m_play = 0; m_phase = 0; m_x = X_INIT; m_dir = 1; m_ticks = 0; m_y = Y_INIT;
  endtask

  task automatic m_step(input bit s, input bit o);
    if (!m_play) begin
      if (s) begin m_play = 1; m_phase = 0; end
    end else if (o) begin
      m_play = 0; m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        m_ticks++;
        if (m_dir > 0) begin
          if (m_x + STEP >= X_MAX) begin m_x = X_MAX; m_dir = -1; end
          else m_x = m_x + STEP;
        end else begin
          if (m_x <= X_MIN + STEP) begin m_x = X_MIN; m_dir = 1; end
          else m_x = m_x - STEP;
        end
      end
`ifdef KONG_JUMP_EN
      m_y = (m_frame() == 2) ? Y_INIT - 8 : Y_INIT;
`endif
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"}, int'(state), m_play);
    chk({tag, ".x"}, int'(x), m_x);
    chk({tag, ".y"}, int'(y), m_y);
    chk({tag, ".anim"}, int'(animation_state), m_frame());
    chk({tag, ".anicnt"}, int'(anicnt), m_ticks % 16);
  endtask

  // one clock: drive, edge, advance model, sample 1 time unit later
  task automatic cyc(input bit s, input bit o, input string tag);
    start = s; over = o;
    @(posedge clk);
    m_step(s, o);
    #1;
    chk_all(tag);
  endtask

  // async reset landing between edges, checked before the next edge
  task automatic async_reset(input string tag);
    #1 rst = 1'b1;
    #1;
    m_reset();
    chk_all(tag);
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0; over = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int fx, fa;
    bit seen;
    rst = 1'b1; start = 1'b0; over = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.state", int'(state), 0);
    chk("rst.x", int'(x), 320);
    chk("rst.y", int'(y), 64);
    chk("rst.anim", int'(animation_state), 0);
    chk("rst.anicnt", int'(anicnt), 0);
    rst = 1'b0;

    repeat (10) cyc(0, 0, "idle");
    cyc(1, 0, "enter");
    chk("enter.state", int'(state), 1);
    repeat (4) cyc(0, 0, "run");
    chk("tick1.x", int'(x), 322);
    chk("tick1.anicnt", int'(anicnt), 1);
    repeat (8) cyc(0, 0, "run");
    chk("tick3.x_clamp", int'(x), 326);
    repeat (4) cyc(0, 0, "run");
    chk("tick4.x_left", int'(x), 324);
    repeat (48) cyc(0, 0, "run");
    chk("tick16.anicnt", int'(anicnt), 0);
    chk("tick16.anim", int'(animation_state), 1);
    repeat (192) cyc(0, 0, "run");
    chk("tick64.anim", int'(animation_state), 0);

    // drive leftward until the model sits on the left bound
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc(0, 0, "seek");
      if (m_x == X_MIN && m_phase == 0) seen = 1;
    end
    chk("leftbound.reached", int'(seen), 1);
    chk("leftbound.x", int'(x), 316);
    repeat (4) cyc(0, 0, "run");
    chk("leftbound.bounce", int'(x), 318);

    repeat (2) cyc(0, 0, "run");
    cyc(0, 1, "over");
    chk("over.state", int'(state), 0);
    fx = m_x; fa = m_ticks % 16;
    repeat (20) cyc(0, 0, "frozen");
    chk("frozen.x", int'(x), fx);
    chk("frozen.anicnt", int'(anicnt), fa);
    cyc(1, 0, "resume");
    repeat (4) cyc(0, 0, "resume");
    chk("resume.moved", int'(x != 10'(fx)), 1);

    repeat (7) cyc(0, 0, "run");
    async_reset("arst");
    cyc(1, 1, "both");
    chk("both.state", int'(state), 1);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset("rnd_arst");
      else cyc($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/kong.md
Name: kong

Overview:
- Enemy-character controller for the Kong sprite in the platform game.
- Holds an idle/play state, patrols horizontally between two bounds while playing, and advances a 4-frame animation.
- Exports sprite position and animation indices to the VGA renderer.
- Driven by the game-flow controller through `start` and `over`.

Parameters:
- X_INIT, 320: x coordinate after reset (pixels, 0..639).
- Y_INIT, 64: y coordinate after reset (pixels, 0..479).
- X_MIN, 160: left patrol bound (inclusive).
- X_MAX, 480: right patrol bound (inclusive); X_MIN <= X_INIT <= X_MAX required.
- STEP, 1: pixels moved per tick.
- TICK_DIV, 416667: clk cycles per game tick (≈60 Hz at 25 MHz); minimum 1.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  level; begin play.
- `over`  in  1  level; game over, freeze Kong.
- `x`  out  10  sprite left x.
- `y`  out  9  sprite top y.
- `state`  out  1  0 = IDLE, 1 = PLAY.
- `animation_state`  out  2  current animation frame 0..3.
- `anicnt`  out  4  tick counter within current frame.

Behaviour:
- Reset (async, `rst`=1): `state`=0, `x`=X_INIT, `y`=Y_INIT, `animation_state`=0, `anicnt`=0, internal tick divider=0, direction=right. All outputs are registers.
- IDLE (`state`=0):
  - All outputs hold.
  - `start`=1 sampled at a rising edge → `state`=1 at that edge.
  - `over` ignored in IDLE; `start` and `over` both high → PLAY.
- PLAY (`state`=1):
  - Divider increments every clk; at TICK_DIV-1 it wraps to 0 and asserts the internal tick for that cycle. First tick occurs TICK_DIV cycles after entering PLAY.
  - On tick, `anicnt` increments mod 16. When `anicnt` wraps 15→0, `animation_state` increments mod 4 (3→0).
  - On tick, moving right: `x` += STEP. If `x`+STEP >= X_MAX, set `x`=X_MAX and direction=left.
  - On tick, moving left: `x` -= STEP. If `x` <= X_MIN+STEP, set `x`=X_MIN and direction=right. No underflow/overflow past bounds.
  - `y` stays Y_INIT (see optional feature).
  - `start` ignored while in PLAY.
- `over`=1 in PLAY at a rising edge → `state`=0 at that edge. `x`, `y`, `animation_state`, `anicnt`, direction freeze at current values. Divider clears to 0.
- Re-entering PLAY via `start` without reset resumes from frozen position, frame and direction.
- Reset mid-play forces all reset values immediately, independent of clk.
- Zero latency to state change: one edge.

Optional Feature:
- Macro KONG_JUMP_EN.
- Defined: in PLAY, `y`=Y_INIT-8 while `animation_state`==2, else `y`=Y_INIT (registered, updates on the same edge as `animation_state`). In IDLE `y` holds.
- Not defined: `y` constant Y_INIT at all times after reset.

Test Plan (TICK_DIV=4, STEP=2, X_INIT=320, X_MIN=316, X_MAX=326, Y_INIT=64):
- Hold `rst` 3 cycles → `state`=0, `x`=320, `y`=64, `animation_state`=0, `anicnt`=0. Outputs unchanged for 10 cycles with `start`=0.
- Release `rst`, pulse `start` 1 cycle → `state`=1 next edge. After 4 cycles `x`=322, `anicnt`=1; after 12 cycles `x`=326 (clamped), direction left; next tick `x`=324.
- Run 16 ticks from play entry → `anicnt` back to 0, `animation_state`=1. After 64 ticks `animation_state` wraps to 0.
- Run left to bound → `x` stops at 316, then increases to 318 on next tick.
- Assert `over` 1 cycle in PLAY → `state`=0 next edge; `x`/`anicnt` frozen 20 cycles. `start` again → motion resumes from frozen `x`.
- Assert `rst` mid-play between clock edges → outputs return to reset values without waiting for an edge. `start`+`over` together in IDLE → `state`=1.
